// File: rtl/mux_rr_feeder_if.sv
// Handshake and mux-side signal bundle for mux_rr_feeder.
// master = the feeder itself, slave = request sources, the mux and the downstream consumer.
interface mux_rr_feeder_if #(
  parameter int WIDTH = 8
);
  logic [7:0]       req;
  logic [WIDTH-1:0] mux_out;
  logic [2:0]       sel;
  logic [7:0]       ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;

  modport master (
    input  req, mux_out, out_ready,
    output sel, ack, out_valid, out_data, busy
  );

  modport slave (
    output req, mux_out, out_ready,
    input  sel, ack, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux_rr_feeder.sv
// Round-robin feeder driving the select of an 8:1 byte mux and forwarding the captured byte.
// Optional macro MUX_RR_BACK2BACK_EN: on a handshake with pending requests, re-grant straight from HOLD.
module mux_rr_feeder #(
  parameter int WIDTH     = 8,
  parameter int PTR_RESET = 0
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_feeder_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [2:0] PTR_INIT = 3'(PTR_RESET);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       ack_q, ack_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [2:0]       grant_base;
  logic [2:0]       grant_idx;
  logic             grant_found;

  // Priority scan starts at the pointer; in back-to-back mode HOLD scans from the channel after sel.
  always_comb begin
`ifdef MUX_RR_BACK2BACK_EN
    grant_base = (state_q == HOLD) ? 3'(sel_q + 3'd1) : ptr_q;
`else
    grant_base = ptr_q;
`endif
    grant_idx   = grant_base;
    grant_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!grant_found && bus.req[3'(grant_base + 3'(k))]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(grant_base + 3'(k));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    ack_d       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          sel_d   = grant_idx;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d  = bus.mux_out;
        out_valid_d = 1'b1;
        ack_d       = 8'd1 << sel_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = 3'(sel_q + 3'd1);
          state_d     = IDLE;
`ifdef MUX_RR_BACK2BACK_EN
          if (grant_found) begin
            sel_d   = grant_idx;
            state_d = CAPTURE;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_INIT;
      sel_q       <= 3'd0;
      ack_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
